// File: rtl/ex_stage_if.sv
// Interface bundling the ID->EX->MEM handshake, data SRAM request and forwarding signals of ex_stage.
// The slave modport is the EX stage; the master modport is the surrounding pipeline.
interface ex_stage_if;
    logic         mem_allowin;
    logic         ex_allowin;
    logic         id_to_ex_valid;
    logic [151:0] id_reg;
    logic         ex_to_mem_valid;
    logic [103:0] ex_reg;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         ex_valid_o;
    logic         ex_gr_we_o;
    logic [4:0]   ex_dest_o;
    logic         ex_res_from_mem_o;
    logic [31:0]  ex_result_o;

    modport slave (
        input  mem_allowin, id_to_ex_valid, id_reg,
        output ex_allowin, ex_to_mem_valid, ex_reg,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               ex_valid_o, ex_gr_we_o, ex_dest_o, ex_res_from_mem_o, ex_result_o
    );

    modport master (
        output mem_allowin, id_to_ex_valid, id_reg,
        input  ex_allowin, ex_to_mem_valid, ex_reg,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               ex_valid_o, ex_gr_we_o, ex_dest_o, ex_res_from_mem_o, ex_result_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: latches the ID bundle, computes ALU / iterative divide results,
// issues the data SRAM request on the transfer cycle and forwards hazard info to ID.
module ex_stage (
    input  logic    clk,
    input  logic    reset,
    ex_stage_if.slave io
);
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    logic         ex_valid_q, ex_valid_d;
    logic [151:0] id_q, id_d;
    div_state_e   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  quo_q, quo_d;
    logic [31:0]  dvs_q, dvs_d;

    // Stage-register fields
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [31:0] src1, src2, rkd_value, pc;
    logic        res_from_mem, mem_we, gr_we;
    logic [4:0]  dest;

    assign {alu_op, div_op, src1, src2, res_from_mem, mem_we, gr_we,
            dest, rkd_value, pc} = id_q;

    // ALU: one-hot select, so the terms are simply OR-ed together
    logic signed [31:0] src1_s;
    logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res;
    logic [31:0] alu_res;

    assign src1_s   = src1;
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = src1_s >>> src2[4:0];

    assign alu_res = ({32{alu_op[0]}}  & add_res)
                   | ({32{alu_op[1]}}  & sub_res)
                   | ({32{alu_op[2]}}  & slt_res)
                   | ({32{alu_op[3]}}  & sltu_res)
                   | ({32{alu_op[4]}}  & (src1 & src2))
                   | ({32{alu_op[5]}}  & ~(src1 | src2))
                   | ({32{alu_op[6]}}  & (src1 | src2))
                   | ({32{alu_op[7]}}  & (src1 ^ src2))
                   | ({32{alu_op[8]}}  & sll_res)
                   | ({32{alu_op[9]}}  & srl_res)
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & src2);

    // Divider operand conditioning; the stage register holds the operands for the whole divide
    logic        is_div, signed_op, s1_neg, s2_neg, div_zero;
    logic [31:0] abs1, abs2;
    logic [32:0] trial;
    logic        ge;

    assign is_div    = |div_op;
    assign signed_op = div_op[0] | div_op[1];
    assign s1_neg    = signed_op & src1[31];
    assign s2_neg    = signed_op & src2[31];
    assign abs1      = s1_neg ? -src1 : src1;
    assign abs2      = s2_neg ? -src2 : src2;
    assign div_zero  = (src2 == 32'd0);
    assign trial     = {rem_q, quo_q[31]};
    assign ge        = (trial >= {1'b0, dvs_q});

    logic [31:0] q_res, r_res, div_res, alu_result;

    assign q_res      = div_zero ? 32'hFFFF_FFFF : ((s1_neg ^ s2_neg) ? -quo_q : quo_q);
    assign r_res      = div_zero ? src1 : (s1_neg ? -rem_q : rem_q);
    assign div_res    = (div_op[0] | div_op[2]) ? q_res : r_res;
    assign alu_result = is_div ? div_res : alu_res;

    // Handshake
    logic ready_go, ex_allowin, ex_to_mem_valid;

    assign ready_go        = !is_div || (state_q == DIV_DONE);
    assign ex_allowin      = !ex_valid_q || (ready_go && io.mem_allowin);
    assign ex_to_mem_valid = ex_valid_q && ready_go;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        ex_valid_d = ex_valid_q;
        id_d       = id_q;
        if (ex_allowin) begin
            ex_valid_d = io.id_to_ex_valid;
        end
        if (io.id_to_ex_valid && ex_allowin) begin
            id_d = io.id_reg;
        end
    end

    // Divider FSM next state; frozen entirely while MEM back-pressures
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (io.mem_allowin) begin
            case (state_q)
                DIV_IDLE: begin
                    if (ex_valid_q && is_div) begin
                        state_d = DIV_BUSY;
                        cnt_d   = 5'd0;
                        rem_d   = 32'd0;
                        quo_d   = abs1;
                        dvs_d   = abs2;
                    end
                end
                DIV_BUSY: begin
                    rem_d = ge ? (trial[31:0] - dvs_q) : trial[31:0];
                    quo_d = {quo_q[30:0], ge};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ex_to_mem_valid) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            state_q    <= DIV_IDLE;
            cnt_q      <= 5'd0;
        end else begin
            ex_valid_q <= ex_valid_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are qualified by ex_valid_q and state_q.
    always_ff @(posedge clk) begin
        id_q  <= id_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign io.ex_allowin        = ex_allowin;
    assign io.ex_to_mem_valid   = ex_to_mem_valid;
    assign io.ex_reg            = {res_from_mem, mem_we, gr_we, dest, alu_result, rkd_value, pc};
    assign io.data_sram_en      = ex_valid_q && (res_from_mem || mem_we) && io.mem_allowin;
    assign io.data_sram_we      = {4{ex_valid_q && mem_we && io.mem_allowin}};
    assign io.data_sram_addr    = alu_result;
    assign io.data_sram_wdata   = rkd_value;
    assign io.ex_valid_o        = ex_valid_q;
    assign io.ex_gr_we_o        = gr_we && ex_valid_q;
    assign io.ex_dest_o         = dest;
    assign io.ex_res_from_mem_o = res_from_mem && ex_valid_q;
    assign io.ex_result_o       = alu_result;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand-written multi-cycle
// sequences, and randomized instructions checked against an arithmetic reference model.
module tb_ex_stage;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ex_stage_if io ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          op;   // 0..11 alu_op bit, 12..15 div/mod/divu/modu
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return sa >>> b[4:0];
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input int dop, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic want_q;
        sa = a;
        sb = b;
        want_q = (dop == 0) || (dop == 2);
        if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
        if (dop < 2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
            sq = sa / sb;
            sr = sa % sb;
            return want_q ? sq : sr;
        end
        return want_q ? (a / b) : (a % b);
    endfunction

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        return (op < 12) ? ref_alu(op, a, b) : ref_div(op - 12, a, b);
    endfunction

    function automatic logic [151:0] mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                        input logic rfm, input logic we, input logic gw,
                                        input logic [4:0] dst, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        logic [11:0] aop;
        logic [3:0]  dop;
        aop = '0;
        dop = '0;
        if (op < 12) aop[op] = 1'b1;
        else         dop[op-12] = 1'b1;
        return {aop, dop, a, b, rfm, we, gw, dst, rkd, pc};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 with EX empty; returns at posedge+1 of the instruction's first EX cycle
    task automatic send(input logic [151:0] b);
        io.id_to_ex_valid = 1'b1;
        io.id_reg         = b;
        @(posedge clk); #1;
        io.id_to_ex_valid = 1'b0;
    endtask

    // Waits (bounded) for the transfer cycle; returns at its negedge, cyc = 0 on timeout
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (io.ex_to_mem_valid && io.mem_allowin) begin
                cyc = c;
                return;
            end
        end
    endtask

    initial begin
        int          cyc;
        int          cnt_a, cnt_b, cnt_c;
        logic [31:0] exp;
        logic [151:0] b;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_ovf"};
        vecs[1]  = '{1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap"};
        vecs[2]  = '{2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg"};
        vecs[3]  = '{3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big"};
        vecs[4]  = '{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};
        vecs[5]  = '{5,  32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, "nor"};
        vecs[6]  = '{6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, "or"};
        vecs[7]  = '{7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor"};
        vecs[8]  = '{8,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, "sll_31"};
        vecs[9]  = '{9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srl"};
        vecs[10] = '{10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, "sra"};
        vecs[11] = '{11, 32'h0000_0123, 32'hABCD_0000, 32'hABCD_0000, "lui"};
        vecs[12] = '{12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[13] = '{13, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "mod_m7_2"};
        vecs[14] = '{14, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0"};
        vecs[15] = '{15, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, "modu_by0"};
        vecs[16] = '{12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_min_m1"};
        vecs[17] = '{13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mod_min_m1"};
        vecs[18] = '{12, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[19] = '{13, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "mod_7_m2"};
        vecs[20] = '{13, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, "mod_by0_signed"};
        vecs[21] = '{14, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, "divu_16"};

        io.id_to_ex_valid = 1'b0;
        io.id_reg         = '0;
        io.mem_allowin    = 1'b1;
        reset             = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_allowin",  io.ex_allowin, 1'b1);
        check("rst_to_mem",   io.ex_to_mem_valid, 1'b0);
        check("rst_sram_en",  io.data_sram_en, 1'b0);
        check("rst_sram_we",  io.data_sram_we, 4'h0);
        check("rst_valid",    io.ex_valid_o, 1'b0);
        check("rst_gr_we",    io.ex_gr_we_o, 1'b0);
        @(posedge clk); #1;

        // Single add, full forwarding view
        send(mk(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h100));
        @(negedge clk);
        check("add_to_mem",  io.ex_to_mem_valid, 1'b1);
        check("add_result",  io.ex_reg[95:64], 32'h8000_0000);
        check("add_gr_we",   io.ex_gr_we_o, 1'b1);
        check("add_dest",    io.ex_dest_o, 5'd5);
        check("add_sram_en", io.data_sram_en, 1'b0);
        check("add_fwd",     io.ex_result_o, 32'h8000_0000);
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 22; i++) begin
            send(mk(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b1, i[4:0], 32'h0, 32'h2000 + 4 * i));
            wait_done(cyc);
            check({vecs[i].name, "_result"}, io.ex_reg[95:64], vecs[i].exp);
            check({vecs[i].name, "_cycles"}, cyc, (vecs[i].op >= 12) ? 34 : 1);
            @(posedge clk); #1;
        end

        // Store stalled for 3 cycles
        io.mem_allowin = 1'b0;
        send(mk(0, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h300));
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (io.data_sram_we != 4'h0 || io.data_sram_en) cnt_a++;
            if (io.ex_allowin) cnt_b++;
            @(posedge clk); #1;
        end
        io.mem_allowin = 1'b1;
        @(negedge clk);
        check("st_stall_writes", cnt_a, 0);
        check("st_stall_allowin", cnt_b, 0);
        check("st_we",    io.data_sram_we, 4'hF);
        check("st_en",    io.data_sram_en, 1'b1);
        check("st_addr",  io.data_sram_addr, 32'h1000);
        check("st_wdata", io.data_sram_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("st_after_we", io.data_sram_we, 4'h0);
        @(posedge clk); #1;

        // Divide finishes under back-pressure, then back-to-back divide
        send(mk(12, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h400));
        cnt_a = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (io.ex_to_mem_valid) cnt_a++;
        end
        check("bp_early_valid", cnt_a, 0);
        @(posedge clk); #1;
        io.mem_allowin    = 1'b0;
        io.id_to_ex_valid = 1'b1;
        io.id_reg         = mk(14, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h404);
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!io.ex_to_mem_valid) cnt_a++;
            if (io.ex_allowin) cnt_b++;
            if (io.ex_reg[95:64] !== 32'hFFFF_FFFD) cnt_c++;
            @(posedge clk); #1;
        end
        check("bp_done_valid", cnt_a, 0);
        check("bp_allowin_low", cnt_b, 0);
        check("bp_result_stable", cnt_c, 0);
        io.mem_allowin = 1'b1;
        @(negedge clk);
        check("bp_release_valid", io.ex_to_mem_valid, 1'b1);
        check("bp_release_allowin", io.ex_allowin, 1'b1);
        check("bp_release_result", io.ex_reg[95:64], 32'hFFFF_FFFD);
        @(posedge clk); #1;
        io.id_to_ex_valid = 1'b0;
        wait_done(cyc);
        check("b2b_cycles", cyc, 34);
        check("b2b_result", io.ex_reg[95:64], ref_div(2, 32'd100, 32'd7));
        @(posedge clk); #1;

        // Reset while the divider is at counter 10
        send(mk(12, 32'h1234_5678, 32'd3, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0, 32'h500));
        repeat (11) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstdiv_valid",   io.ex_valid_o, 1'b0);
        check("rstdiv_to_mem",  io.ex_to_mem_valid, 1'b0);
        check("rstdiv_allowin", io.ex_allowin, 1'b1);
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (io.ex_to_mem_valid || io.data_sram_en) cnt_a++;
        end
        check("rstdiv_no_issue", cnt_a, 0);
        @(posedge clk); #1;
        send(mk(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h600));
        wait_done(cyc);
        check("rstdiv_add_cycles", cyc, 1);
        check("rstdiv_add_result", io.ex_reg[95:64], 32'd7);
        @(posedge clk); #1;

        // Randomized instructions with random back-pressure
        for (int t = 0; t < 150; t++) begin
            int          op, mkind, stray, ready_bad, done;
            logic [31:0] a, bb, rkd, pc;
            logic        rfm, we;
            logic [4:0]  dst;
            op    = $urandom_range(0, 15);
            a     = pick();
            bb    = pick();
            rkd   = $urandom;
            pc    = $urandom;
            dst   = 5'($urandom_range(0, 31));
            mkind = (op < 12) ? $urandom_range(0, 3) : 3;
            rfm   = (mkind == 0);
            we    = (mkind == 1);
            exp   = ref_result(op, a, bb);
            b     = mk(op, a, bb, rfm, we, 1'b1, dst, rkd, pc);
            io.mem_allowin = ($urandom_range(0, 9) < 7);
            send(b);
            stray     = 0;
            ready_bad = 0;
            done      = 0;
            cyc       = 0;
            for (int c = 1; c <= 600; c++) begin
                @(negedge clk);
                if (io.ex_to_mem_valid && io.mem_allowin) begin
                    done = 1;
                    cyc  = c;
                    break;
                end
                if (io.data_sram_we != 4'h0 || io.data_sram_en) stray++;
                if (op < 12 && !io.ex_to_mem_valid) ready_bad++;
                @(posedge clk); #1;
                io.mem_allowin = ($urandom_range(0, 9) < 7);
            end
            check("rnd_done", done, 1);
            check("rnd_ex_reg", io.ex_reg, {rfm, we, 1'b1, dst, exp, rkd, pc});
            check("rnd_sram_we", io.data_sram_we, {4{we}});
            check("rnd_sram_en", io.data_sram_en, rfm | we);
            if (rfm | we) check("rnd_sram_addr", io.data_sram_addr, exp);
            check("rnd_stray_access", stray, 0);
            check("rnd_ready", ready_bad, 0);
            if (op >= 12) check("rnd_div_min_cycles", cyc >= 34, 1'b1);
            @(posedge clk); #1;
            io.mem_allowin = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage in-order core; sits between ID and MEM.
- Latches the decoded bundle from ID and computes the ALU result.
- Runs an iterative 32-cycle divider for div/mod ops.
- Issues the data SRAM request for loads and stores, and hands the 104-bit bundle to MEM.
- Exports forwarding/hazard info to ID.

Parameters:
- None (datapath fixed at 32 bits; bus widths below are fixed).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_allowin  in  1  MEM can accept this cycle
- ex_allowin  out  1  EX can accept from ID
- id_to_ex_valid  in  1  ID bundle valid
- id_reg  in  152  {alu_op[11:0], div_op[3:0], src1[31:0], src2[31:0], res_from_mem, mem_we, gr_we, dest[4:0], rkd_value[31:0], pc[31:0]}, MSB first
- ex_to_mem_valid  out  1  bundle to MEM valid
- ex_reg  out  104  {res_from_mem, mem_we, gr_we, dest[4:0], alu_result[31:0], rkd_value[31:0], pc[31:0]}, MSB first
- data_sram_en  out  1  SRAM access enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  address
- data_sram_wdata  out  32  write data
- ex_valid_o  out  1  EX holds a valid instruction
- ex_gr_we_o  out  1  gr_we && ex_valid
- ex_dest_o  out  5  destination register
- ex_res_from_mem_o  out  1  load in EX (ID uses it for load-use stall)
- ex_result_o  out  32  alu_result, for forwarding

Behaviour:
- Handshake:
  - ex_allowin = !ex_valid || (ready_go && mem_allowin).
  - ex_to_mem_valid = ex_valid && ready_go.
  - Every clk edge with ex_allowin: ex_valid <= id_to_ex_valid.
  - id_reg is captured into the stage register only when id_to_ex_valid && ex_allowin; otherwise the register holds.
- Reset: ex_valid=0, divider state=IDLE, counter=0. Consequently ex_allowin=1, ex_to_mem_valid=0, data_sram_en=0, data_sram_we=0, ex_valid_o=0, ex_gr_we_o=0. Data registers are don't-care.
- ALU ops (alu_op one-hot, bit 0..11): add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shift amount = src2[4:0].
  - lui result = src2.
  - slt/sltu produce 0 or 1.
  - All arithmetic wraps modulo 2^32.
- Divider (div_op one-hot: div, mod, divu, modu; div_op==0 means not a divide):
  - IDLE: when ex_valid && div_op!=0, latch |src1|, |src2| (signed ops) or raw values (unsigned), plus sign flags; go to BUSY, counter=0.
  - BUSY: one restoring quotient bit per cycle; counter increments; after counter==31 go to DONE.
  - DONE: hold result. Go to IDLE on the edge where ex_to_mem_valid && mem_allowin.
  - Sign fix-up: quotient negated if operand signs differ; remainder takes the sign of the dividend.
  - Divisor 0: quotient=0xFFFFFFFF, remainder=src1, for both signed and unsigned ops.
  - 0x80000000 div -1: quotient 0x80000000, remainder 0.
  - alu_result = quotient (div/divu) or remainder (mod/modu).
- ready_go:
  - Divide op: ready_go = 1 only in DONE.
  - Any other op: ready_go = 1.
  - Minimum residency for a divide: 34 cycles (1 IDLE + 32 BUSY + 1 DONE).
- Memory request (stage register fields):
  - data_sram_en = ex_valid && (res_from_mem || mem_we) && mem_allowin.
  - data_sram_we = {4{ex_valid && mem_we && mem_allowin}}.
  - data_sram_addr = alu_result; data_sram_wdata = rkd_value.
  - A request is issued exactly in the cycle the instruction transfers to MEM. A stalled store never writes more than once.
  - Load data is therefore valid at the SRAM output in the cycle the load is in MEM. The SRAM holds rdata while en=0.
- Back-pressure: while !mem_allowin, the stage register, divider state and all outputs hold; no SRAM access.
- Simultaneous events: leaving DONE and accepting a new divide on the same edge is allowed. The next instruction sees IDLE on the following cycle and starts normally.
- Reset mid-division: the divider aborts on that edge; nothing is issued to MEM or the SRAM afterwards.
- Forwarding: ex_dest_o = dest and ex_result_o = alu_result, both regardless of valid. ex_res_from_mem_o = res_from_mem && ex_valid.

Test Plan:
- add, src1=0x7FFFFFFF, src2=1, gr_we=1, dest=5, mem_allowin=1 -> next cycle ex_to_mem_valid=1, ex_reg.alu_result=0x80000000, ex_gr_we_o=1, ex_dest_o=5, data_sram_en=0.
- Store, addr=0x1000, rkd_value=0xDEADBEEF, mem_allowin low for 3 cycles then high -> data_sram_we=4'hF asserted exactly one cycle (the transfer cycle), addr=0x1000, wdata=0xDEADBEEF; zero writes during the stall.
- div, src1=-7 (0xFFFFFFF9), src2=2 -> ex_to_mem_valid low for 33 cycles, high on the 34th, alu_result=0xFFFFFFFD; same with mod -> 0xFFFFFFFF.
- divu by 0, src1=0x12345678 -> quotient 0xFFFFFFFF; modu by 0 -> 0x12345678. div 0x80000000 by 0xFFFFFFFF -> 0x80000000.
- Divide completes with mem_allowin=0 for 5 cycles -> stays in DONE, ex_allowin=0, result stable; on release it transfers, and a back-to-back divide starts the next cycle.
- reset asserted at BUSY counter=10 -> next cycle ex_valid_o=0, ex_to_mem_valid=0, ex_allowin=1; a subsequent add completes with correct result.
